// File: rtl/genome_mutator.sv
// Mutation stage: walks every genome weight, randomly perturbs it by a small signed delta.
// Optional GENOME_MUTATOR_SATURATE_EN clamps the updated weight instead of wrapping it.
module genome_mutator #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int GENOME_LEN   = 48
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [7:0]              rate,
  input  logic [15:0]             rnd,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd_en,
  input  logic [WEIGHT_WIDTH-1:0] mem_rd_data,
  output logic                    mem_wr_en,
  output logic [WEIGHT_WIDTH-1:0] mem_wr_data,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     mutated_count
);
  localparam int W = WEIGHT_WIDTH;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(GENOME_LEN - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            rate_q, rate_d;
  logic [W-1:0]          weight_q, weight_d;
  logic [W-1:0]          wr_data_q, wr_data_d;
  logic                  flag_q, flag_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic [W:0]   delta_ext, sum;
  logic [W-1:0] new_weight;
  logic         rnd_unused;

  assign rnd_unused = ^rnd[7:4];
  assign delta_ext  = {{(W-3){rnd[3]}}, rnd[3:0]};
  // One extra bit of headroom so overflow is visible as sum[W] != sum[W-1].
  assign sum        = {weight_q[W-1], weight_q} + delta_ext;

`ifdef GENOME_MUTATOR_SATURATE_EN
  always_comb begin
    new_weight = sum[W-1:0];
    if (sum[W] != sum[W-1])
      new_weight = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  assign new_weight = sum[W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rate_d    = rate_q;
    weight_d  = weight_q;
    wr_data_d = wr_data_q;
    flag_d    = flag_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE: if (start) begin
        rate_d  = rate;
        count_d = '0;
        addr_d  = '0;
        state_d = S_READ;
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        weight_d = mem_rd_data;
        state_d  = S_DECIDE;
      end
      S_DECIDE: begin
        flag_d = rnd[15:8] < rate_q;
        if (flag_d) begin
          wr_data_d = new_weight;
          count_d   = count_q + (ADDR_WIDTH+1)'(1);
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) state_d = S_DONE;
        else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rate_q    <= '0;
      weight_q  <= '0;
      wr_data_q <= '0;
      flag_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rate_q    <= rate_d;
      weight_q  <= weight_d;
      wr_data_q <= wr_data_d;
      flag_q    <= flag_d;
      count_q   <= count_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_rd_en     = (state_q == S_READ);
  assign mem_wr_en     = (state_q == S_WRITE) && flag_q;
  assign mem_wr_data   = wr_data_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign mutated_count = count_q;
endmodule

// File: tb/tb_genome_mutator.sv
// Bench for genome_mutator: a cycle-level pass model checked every cycle plus literal RAM/count checks.
module tb_genome_mutator;
  localparam int N = 4;
  localparam int PASS_CYC = 4 * N + 1;

  logic       clock = 1'b0;
  logic       resetn, start;
  logic [7:0] rate;
  logic [15:0] rnd;
  logic [5:0] mem_addr;
  logic       mem_rd_en, mem_wr_en, busy, done;
  logic [7:0] mem_rd_data, mem_wr_data;
  logic [6:0] mutated_count;

  genome_mutator #(.WEIGHT_WIDTH(8), .ADDR_WIDTH(6), .GENOME_LEN(N)) dut (
    .clock(clock), .resetn(resetn), .start(start), .rate(rate), .rnd(rnd),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .busy(busy), .done(done),
    .mutated_count(mutated_count)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [64];
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected new weight from the arithmetic rule, independent of any bit tricks.
  function automatic logic [7:0] mutate(input logic [7:0] w, input logic [3:0] d);
    int wi, di, s;
    wi = (w > 127) ? int'(w) - 256 : int'(w);
    di = (d > 7) ? int'(d) - 16 : int'(d);
    s  = wi + di;
`ifdef GENOME_MUTATOR_SATURATE_EN
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`endif
    return 8'(s & 255);
  endfunction

  logic [7:0] mref [N];
  bit         m_flag [N];
  logic [7:0] m_new [N];
  bit   m_act = 0, m_rst = 0;
  int   m_cyc = 0, m_cnt = 0;
  logic [7:0] m_rate = 0;

  always @(negedge clock) begin
    int ph, a;
    if (resetn === 1'b1) begin
      if (m_act) begin
        ph = (m_cyc - 1) % 4;
        a  = (m_cyc - 1) / 4;
        chk("busy", 32'(busy), 1);
        if (m_cyc == PASS_CYC) begin
          chk("done", 32'(done), 1);
          chk("count_at_done", 32'(mutated_count), 32'(m_cnt));
          chk("rd_en", 32'(mem_rd_en), 0);
          chk("wr_en", 32'(mem_wr_en), 0);
        end else begin
          chk("done", 32'(done), 0);
          chk("rd_en", 32'(mem_rd_en), 32'(ph == 0));
          chk("addr", 32'(mem_addr), 32'(a));
          chk("wr_en", 32'(mem_wr_en), 32'(ph == 3 && m_flag[a]));
          if (ph == 3 && m_flag[a]) chk("wr_data", 32'(mem_wr_data), 32'(m_new[a]));
          if (ph == 2) begin
            m_flag[a] = rnd[15:8] < m_rate;
            m_new[a]  = mutate(mref[a], rnd[3:0]);
            if (m_flag[a]) m_cnt++;
          end
          if (ph == 3 && m_flag[a]) mref[a] = m_new[a];
        end
      end else begin
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_rd_en", 32'(mem_rd_en), 0);
        chk("idle_wr_en", 32'(mem_wr_en), 0);
        chk("idle_count", 32'(mutated_count), 32'(m_cnt));
        if (m_rst) begin
          chk("rst_addr", 32'(mem_addr), 0);
          chk("rst_wr_data", 32'(mem_wr_data), 0);
        end
      end
      m_rst = 0;
    end
    if (resetn !== 1'b1) begin
      m_act = 0; m_cnt = 0; m_rst = 1;
    end else if (m_act) begin
      if (m_cyc == PASS_CYC) m_act = 0;
      else m_cyc++;
    end else if (start) begin
      m_act = 1; m_cyc = 1; m_rate = rate; m_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic load(input logic [7:0] w0, w1, w2, w3);
    ram[0] = w0; ram[1] = w1; ram[2] = w2; ram[3] = w3;
    for (int i = 0; i < N; i++) mref[i] = ram[i];
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200 && done !== 1'b1; k++) tick();
    if (done !== 1'b1) begin n_cmp++; n_bad++; $display("FAIL wait_done: timeout"); end
  endtask

  // Start asserted here; done must appear 4*N+1 edges later.
  task automatic run_pass(input bit hold);
    int k;
    start = 1'b1;
    for (k = 1; k <= 200; k++) begin
      tick();
      if (k == 1 && !hold) start = 1'b0;
      if (done === 1'b1) break;
    end
    chk("done_latency", 32'(k), 32'(PASS_CYC));
  endtask

  task automatic cmp_ram();
    for (int i = 0; i < N; i++) chk($sformatf("ram_vs_model[%0d]", i), 32'(ram[i]), 32'(mref[i]));
  endtask

  initial begin
    int k;
    resetn = 1'b0; start = 1'b0; rate = 8'h00; rnd = 16'h0000;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // rate 0: nothing written
    load(8'h10, 8'h20, 8'h30, 8'h40);
    rate = 8'h00; rnd = 16'h1234;
    run_pass(0);
    chk("r0_count", 32'(mutated_count), 0);
    tick();
    chk("r0_ram0", 32'(ram[0]), 32'h10);
    chk("r0_ram3", 32'(ram[3]), 32'h40);

    // rate 255 with delta +3, start held across DONE->IDLE
    rate = 8'hFF; rnd = 16'h0003;
    run_pass(1);
    chk("r255_count", 32'(mutated_count), 4);
    tick();
    chk("r255_ram0", 32'(ram[0]), 32'h13);
    chk("r255_ram1", 32'(ram[1]), 32'h23);
    chk("r255_ram2", 32'(ram[2]), 32'h33);
    chk("r255_ram3", 32'(ram[3]), 32'h43);
    tick();
    chk("held_start_busy", 32'(busy), 1);
    chk("held_start_rd", 32'(mem_rd_en), 1);
    start = 1'b0;
    wait_done();
    tick();
    chk("second_ram0", 32'(ram[0]), 32'h16);
    chk("second_ram3", 32'(ram[3]), 32'h46);
    cmp_ram();

    // positive overflow
    load(8'h7E, 8'h00, 8'h7F, 8'h01);
    rate = 8'hFF; rnd = 16'h0007;
    run_pass(0);
    tick();
`ifdef GENOME_MUTATOR_SATURATE_EN
    chk("pos_ovf_ram0", 32'(ram[0]), 32'h7F);
`else
    chk("pos_ovf_ram0", 32'(ram[0]), 32'h85);
`endif
    cmp_ram();

    // negative overflow, delta -8
    load(8'h80, 8'h00, 8'h85, 8'hFF);
    rnd = 16'h0008;
    run_pass(0);
    tick();
`ifdef GENOME_MUTATOR_SATURATE_EN
    chk("neg_ovf_ram0", 32'(ram[0]), 32'h80);
`else
    chk("neg_ovf_ram0", 32'(ram[0]), 32'h78);
`endif
    chk("neg_ovf_ram1", 32'(ram[1]), 32'hF8);
    cmp_ram();

    // strict threshold; mid-pass start/rate change ignored
    load(8'h10, 8'h20, 8'h30, 8'h40);
    rate = 8'h40; rnd = 16'h4005;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    start = 1'b1; rate = 8'hFF; tick(); start = 1'b0; rate = 8'h40;
    wait_done();
    chk("strict_count", 32'(mutated_count), 0);
    tick();
    chk("strict_ram1", 32'(ram[1]), 32'h20);
    rnd = 16'h3F05;
    run_pass(0);
    chk("below_count", 32'(mutated_count), 4);
    tick();
    chk("below_ram0", 32'(ram[0]), 32'h15);
    chk("below_ram2", 32'(ram[2]), 32'h35);
    cmp_ram();

    // reset during READ of address 2
    load(8'h01, 8'h02, 8'h03, 8'h04);
    rate = 8'hFF; rnd = 16'h0001;
    start = 1'b1; tick(); start = 1'b0;
    for (k = 0; k < 100 && !(mem_rd_en === 1'b1 && mem_addr == 6'd2); k++) tick();
    chk("saw_read_addr2", 32'(mem_rd_en === 1'b1 && mem_addr == 6'd2), 1);
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(mutated_count), 0);
    repeat (3) tick();
    chk("rst_ram0", 32'(ram[0]), 32'h02);
    chk("rst_ram1", 32'(ram[1]), 32'h03);
    chk("rst_ram2", 32'(ram[2]), 32'h03);
    chk("rst_ram3", 32'(ram[3]), 32'h04);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_rd", 32'(mem_rd_en), 1);
    chk("restart_addr", 32'(mem_addr), 0);
    wait_done();
    tick();
    chk("restart_ram0", 32'(ram[0]), 32'h03);
    chk("restart_ram3", 32'(ram[3]), 32'h05);
    cmp_ram();

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/genome_mutator.md
# genome_mutator

Mutation stage of the neuroevolution datapath; consumes the free-running 16-bit LFSR word and applies random perturbations to one genome stored in an external synchronous weight RAM. On `start` it walks every weight address. For each weight it reads the weight, decides from the random word whether to mutate it, adds a small signed random delta, and writes the result back. It sits between the LFSR (upstream, `rnd`) and the genome RAM / evaluation controller (downstream, `done`).

## Interface
- `WEIGHT_WIDTH`, 8: signed two's-complement weight width (≥5).
- `ADDR_WIDTH`, 6: genome RAM address width.
- `GENOME_LEN`, 48: number of weights, addresses 0..GENOME_LEN-1 (≤2^ADDR_WIDTH).

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a mutation pass; sampled only in IDLE.
- `rate`  in  8  mutation threshold; latched on accepted `start`.
- `rnd`  in  16  LFSR word, advances every cycle; sampled in DECIDE only.
- `mem_addr`  out  ADDR_WIDTH  RAM address for read and write.
- `mem_rd_en`  out  1  read strobe; data valid on `mem_rd_data` the following cycle.
- `mem_rd_data`  in  WEIGHT_WIDTH  read data.
- `mem_wr_en`  out  1  write strobe.
- `mem_wr_data`  out  WEIGHT_WIDTH  write data.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE state.
- `done`  out  1  one-cycle pulse at end of pass.
- `mutated_count`  out  ADDR_WIDTH+1  weights mutated in last/current pass.

## Operation
- States: IDLE, READ, WAIT, DECIDE, WRITE, DONE.
- IDLE: if `start`, latch `rate`, clear `mutated_count`, set addr=0, go to READ. Otherwise stay.
- READ: `mem_rd_en`=1, go to WAIT.
- WAIT: capture `mem_rd_data` into the weight register, go to DECIDE.
- DECIDE: the mutate flag is `rnd[15:8] < rate_q` (strict, unsigned).
  - Delta is `rnd[3:0]`, sign-extended 4-bit (-8..+7).
  - The new weight is the weight plus delta, with width rules per Configuration.
  - If the flag is set, increment `mutated_count`.
  - Go to WRITE.
- WRITE: if flagged, `mem_wr_en`=1 and `mem_wr_data`=new weight. Otherwise there is no write.
  - If addr==GENOME_LEN-1, go to DONE. Otherwise addr+1 and go to READ.
- DONE: `done`=1 for one cycle, go to IDLE.
- A flagged weight with delta 0 is still written and still counted.
- `rate`=0 never mutates. `rate`=255 mutates unless `rnd[15:8]`==0xFF.
- `start` is ignored outside IDLE. `rate` changes mid-pass have no effect.
- `mem_addr` is held constant for the whole READ..WRITE of each weight.
- Strobes are decoded from the registered state: `mem_rd_en` only in READ, `mem_wr_en` only in WRITE. They are never high together.

## Timing
- 4 cycles per weight. `done` pulses 4·GENOME_LEN+1 cycles after the edge on which `start` is accepted.
- `mutated_count` is stable from the `done` cycle until the next accepted `start`. It is cleared on that `start`, not on reset deassertion.
- Reset values: state IDLE, `mem_addr`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_wr_data`=0, `busy`=0, `done`=0, `mutated_count`=0.
- Reset mid-pass: at the reset edge the block returns to IDLE. No further strobes are issued, and weights already written stay written. The next `start` restarts from address 0.
- `start` held high across DONE→IDLE begins a new pass on the first IDLE cycle.

## Configuration
- `GENOME_MUTATOR_SATURATE_EN` defined: the sum is computed at WEIGHT_WIDTH+1 bits and clamped to [-2^(W-1), 2^(W-1)-1].
- `GENOME_MUTATOR_SATURATE_EN` undefined: the sum wraps modulo 2^WEIGHT_WIDTH.
- The macro does not change the decision logic, the counter, or the timing.

## Test plan
All scenarios use WEIGHT_WIDTH=8 and GENOME_LEN=4, with `rnd` driven by the bench.
- `rate`=0, RAM={0x10,0x20,0x30,0x40}, pulse `start` → no `mem_wr_en`; `done` 17 cycles later; `mutated_count`=0; RAM unchanged.
- `rate`=0xFF, `rnd`=0x0003 constant → four writes of {0x13,0x23,0x33,0x43}; `mutated_count`=4.
- Weight 0x7E, `rate`=0xFF, `rnd`=0x0007 → write 0x7F with `GENOME_MUTATOR_SATURATE_EN` defined; 0x85 without it.
- Weight 0x80, `rnd`=0x0008 (delta -8) → write 0x80 saturated; 0x78 wrapped.
- `rate`=0x40, `rnd`=0x4005 → no write (strict compare). `rnd`=0x3F05 → write weight+5.
- Assert `resetn`=0 during READ of address 2 → `busy`=0 and all outputs 0 next cycle; no writes to addresses 2–3. A new `start` reads address 0 first. A second `start` mid-pass is ignored.
